mem_access_scheduler: RTL and testbench
=======================================

Name: mem_access_scheduler

Overview:
- Round-robin scheduler that shares the single external-memory command path among NUM_CORES cores.
- Accepts per-core read/write requests and latches the winner's command.
- Issues the command over a valid/ready interface toward the DDR3 app-side state machine, waits for the response, then returns data/ack to the granted core.
- One transaction outstanding at a time; gated by memory calibration; per-transaction timeout watchdog.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..16).
- ADDR_WIDTH, 28, memory address width.
- DATA_WIDTH, 32, core data word width.
- TIMEOUT_CYCLES, 255, max cycles in WAIT_RSP before abort (1..65535).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low reset.
- core_req  in  NUM_CORES  per-core request, level, held until core_ack.
- core_wren  in  NUM_CORES  per-core 1=write, 0=read; valid with core_req.
- core_addr  in  NUM_CORES*ADDR_WIDTH  packed addresses, core i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- core_wdata  in  NUM_CORES*DATA_WIDTH  packed write data.
- core_grant  out  NUM_CORES  one-hot, current owner; 0 when idle.
- core_ack  out  NUM_CORES  one-cycle one-hot completion pulse.
- core_rdata  out  DATA_WIDTH  read data, valid with core_ack for reads.
- core_err  out  1  pulses with core_ack on timeout.
- mem_calib_done  in  1  memory ready for commands.
- mem_cmd_valid  out  1  command valid.
- mem_cmd_ready  in  1  command accepted when valid&ready.
- mem_cmd_wr  out  1  1=write.
- mem_cmd_addr  out  ADDR_WIDTH  command address.
- mem_cmd_wdata  out  DATA_WIDTH  write data.
- mem_rsp_valid  in  1  one-cycle completion; read data or write done.
- mem_rsp_rdata  in  DATA_WIDTH  read data.

Behaviour:
- Reset (reset==0 at posedge):
  - state=INIT; core_grant=0, core_ack=0, core_err=0, core_rdata=0.
  - mem_cmd_valid=0, mem_cmd_wr=0, mem_cmd_addr=0, mem_cmd_wdata=0.
  - rr_ptr=NUM_CORES-1, so core 0 has highest priority first.
  - Reset mid-transaction drops everything; no ack is issued.
- INIT: stay until mem_calib_done=1, then go to ARB. core_req is ignored in INIT.
- ARB:
  - If any core_req, pick the first set bit scanning from rr_ptr+1 upward with wrap modulo NUM_CORES.
  - Register core_grant (one-hot), latch that core's wren/addr/wdata into mem_cmd_*, set mem_cmd_valid=1, rr_ptr=winner; go to ISSUE.
  - If no core_req, stay in ARB.
- ISSUE:
  - Hold mem_cmd_* stable while mem_cmd_valid=1.
  - On mem_cmd_valid&mem_cmd_ready: mem_cmd_valid=0, clear timeout counter; go to WAIT_RSP.
- WAIT_RSP:
  - On mem_rsp_valid: core_ack=core_grant for one cycle; core_rdata=mem_rsp_rdata if read, else unchanged; go to DONE.
  - Each cycle without a response increments the counter. When the counter reaches TIMEOUT_CYCLES: core_ack and core_err pulse, core_rdata=0; go to DONE.
  - A mem_rsp_valid arriving in the same cycle as the timeout wins (normal ack, no err).
- DONE: core_grant=0, core_ack=0, core_err=0; go to ARB. This gives the core one cycle to drop core_req.
- Latency, request seen in ARB with mem_cmd_ready=1 and zero-latency response:
  - grant at +1;
  - cmd handshake at +1;
  - ack at +3 from request sampling.
- Boundaries:
  - Latched command fields are unaffected by core_addr/core_wdata changes after grant.
  - A granted core dropping core_req early does not cancel the transaction; it completes and the ack is still issued.
  - mem_rsp_valid outside WAIT_RSP is ignored.
  - mem_calib_done deasserting after INIT is ignored.
- Invariants:
  - At most one core_grant bit set; core_ack ⊆ core_grant.
  - A core with core_req continuously high is served within NUM_CORES transactions.

Test Plan:
- Calibration gate: core_req=4'b0001 with mem_calib_done=0 for 20 cycles -> no mem_cmd_valid. Raise calib -> cmd within 2 cycles, addr=core0 addr.
- Single read: core2 reads addr 0x0000100, mem returns 0xCAFECAFE -> core_ack=4'b0100 one cycle, core_rdata=0xCAFECAFE, core_err=0.
- Round-robin: all four cores requesting continuously -> grant order 0,1,2,3,0; each ack pulses exactly once per grant.
- Backpressure: mem_cmd_ready=0 for 10 cycles during a write of 0xBEADBEAD to 0x0000040 -> mem_cmd_valid/addr/wdata stable all 10 cycles; exactly one handshake.
- Timeout: TIMEOUT_CYCLES=8, no mem_rsp_valid -> core_ack and core_err pulse 8 cycles after handshake, core_rdata=0. A later stray mem_rsp_valid is ignored.
- Reset mid-op: reset=0 in WAIT_RSP -> next cycle all outputs 0, state INIT; no core_ack is issued.

Source files
------------

// File: rtl/mem_access_scheduler_if.sv
// Memory-side command/response channel between the core scheduler
// and the DDR3 app-side state machine.
interface mem_access_scheduler_if #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 32
);
   logic                  mem_calib_done;
   logic                  mem_cmd_valid;
   logic                  mem_cmd_ready;
   logic                  mem_cmd_wr;
   logic [ADDR_WIDTH-1:0] mem_cmd_addr;
   logic [DATA_WIDTH-1:0] mem_cmd_wdata;
   logic                  mem_rsp_valid;
   logic [DATA_WIDTH-1:0] mem_rsp_rdata;

   modport master (
      input  mem_calib_done,
      output mem_cmd_valid,
      input  mem_cmd_ready,
      output mem_cmd_wr,
      output mem_cmd_addr,
      output mem_cmd_wdata,
      input  mem_rsp_valid,
      input  mem_rsp_rdata
   );

   modport slave (
      output mem_calib_done,
      input  mem_cmd_valid,
      output mem_cmd_ready,
      input  mem_cmd_wr,
      input  mem_cmd_addr,
      input  mem_cmd_wdata,
      output mem_rsp_valid,
      output mem_rsp_rdata
   );
endinterface

// File: rtl/mem_access_scheduler.sv
// Round-robin arbiter sharing one external-memory command path among
// NUM_CORES cores; one transaction in flight, with a response watchdog.
module mem_access_scheduler #(
   parameter int NUM_CORES      = 4,
   parameter int ADDR_WIDTH     = 28,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_CORES-1:0]             core_req,
   input  logic [NUM_CORES-1:0]             core_wren,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_addr,
   input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_wdata,
   output logic [NUM_CORES-1:0]             core_grant,
   output logic [NUM_CORES-1:0]             core_ack,
   output logic [DATA_WIDTH-1:0]            core_rdata,
   output logic                             core_err,
   mem_access_scheduler_if.master           mem
);

   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [PW-1:0] LAST = PW'(NUM_CORES - 1);
   localparam logic [15:0]   TO_LIM = 16'(TIMEOUT_CYCLES);
   localparam logic [NUM_CORES-1:0] ONE = {{(NUM_CORES-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_INIT,
      S_ARB,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [PW-1:0]           rr_q, rr_d;
   logic [NUM_CORES-1:0]    grant_q, grant_d;
   logic [NUM_CORES-1:0]    ack_q, ack_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    valid_q, valid_d;
   logic                    wr_q, wr_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [15:0]             cnt_q, cnt_d;
   logic [15:0]             cnt_inc;

   logic                    win_found;
   logic [PW-1:0]           win_idx;

   // Scan upward from the core after the last winner, wrapping around.
   always_comb begin
      int s;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NUM_CORES; k++) begin
         s = int'(rr_q) + k;
         if (s >= NUM_CORES) s = s - NUM_CORES;
         if (!win_found && core_req[PW'(s)]) begin
            win_found = 1'b1;
            win_idx   = PW'(s);
         end
      end
   end

   assign cnt_inc = cnt_q + 16'd1;

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      ack_d   = '0;
      err_d   = 1'b0;
      rdata_d = rdata_q;
      valid_d = valid_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_INIT: begin
            if (mem.mem_calib_done) state_d = S_ARB;
         end
         S_ARB: begin
            if (win_found) begin
               grant_d = ONE << win_idx;
               wr_d    = core_wren[win_idx];
               addr_d  = core_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d = core_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
               valid_d = 1'b1;
               rr_d    = win_idx;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (valid_q && mem.mem_cmd_ready) begin
               valid_d = 1'b0;
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // A response in the timeout cycle still completes normally.
            if (mem.mem_rsp_valid) begin
               ack_d   = grant_q;
               if (!wr_q) rdata_d = mem.mem_rsp_rdata;
               state_d = S_DONE;
            end else if (cnt_inc == TO_LIM) begin
               ack_d   = grant_q;
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_DONE: begin
            grant_d = '0;
            state_d = S_ARB;
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_INIT;
         rr_q    <= LAST;
         grant_q <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         valid_q <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         valid_q <= valid_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end

   assign core_grant        = grant_q;
   assign core_ack          = ack_q;
   assign core_err          = err_q;
   assign core_rdata        = rdata_q;
   assign mem.mem_cmd_valid = valid_q;
   assign mem.mem_cmd_wr    = wr_q;
   assign mem.mem_cmd_addr  = addr_q;
   assign mem.mem_cmd_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_scheduler.sv
// Directed bench for mem_access_scheduler: calibration gate, reads,
// round-robin order, backpressure, timeout and mid-transaction reset.
module tb_mem_access_scheduler;

   localparam int NC = 4;
   localparam int AW = 28;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic [NC-1:0]    core_req;
   logic [NC-1:0]    core_wren;
   logic [NC*AW-1:0] core_addr;
   logic [NC*DW-1:0] core_wdata;
   logic [NC-1:0]    core_grant;
   logic [NC-1:0]    core_ack;
   logic [DW-1:0]    core_rdata;
   logic             core_err;

   int errors = 0;
   int checks = 0;

   mem_access_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mif ();

   mem_access_scheduler #(
      .NUM_CORES(NC),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .core_req(core_req),
      .core_wren(core_wren),
      .core_addr(core_addr),
      .core_wdata(core_wdata),
      .core_grant(core_grant),
      .core_ack(core_ack),
      .core_rdata(core_rdata),
      .core_err(core_err),
      .mem(mif.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int order [5];
      order = '{3, 0, 1, 2, 3};
      reset = 1'b0;
      core_req = '0;
      core_wren = '0;
      core_addr = '0;
      core_wdata = '0;
      mif.mem_calib_done = 1'b0;
      mif.mem_cmd_ready = 1'b0;
      mif.mem_rsp_valid = 1'b0;
      mif.mem_rsp_rdata = '0;
      tick();
      tick();
      chk("rst_grant", 64'(core_grant), 64'h0);
      chk("rst_ack_err", 64'({core_ack, core_err}), 64'h0);
      chk("rst_rdata", 64'(core_rdata), 64'h0);
      chk("rst_cmd", 64'({mif.mem_cmd_valid, mif.mem_cmd_wr,
                          mif.mem_cmd_addr, mif.mem_cmd_wdata}), 64'h0);
      reset = 1'b1;

      // Calibration gate
      core_addr[0*AW +: AW] = 28'h0000AA0;
      core_req = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("calib_gate", 64'(mif.mem_cmd_valid), 64'h0);
      end
      mif.mem_calib_done = 1'b1;
      tick();
      chk("calib_arb", 64'(mif.mem_cmd_valid), 64'h0);
      tick();
      chk("calib_cmd", 64'({mif.mem_cmd_valid, core_grant, mif.mem_cmd_addr}),
          64'({1'b1, 4'b0001, 28'h0000AA0}));
      mif.mem_cmd_ready = 1'b1;
      tick();
      chk("hs0", 64'(mif.mem_cmd_valid), 64'h0);
      mif.mem_cmd_ready = 1'b0;
      mif.mem_rsp_valid = 1'b1;
      mif.mem_rsp_rdata = 32'h11112222;
      tick();
      chk("ack0", 64'({core_ack, core_err, core_rdata}),
          64'({4'b0001, 1'b0, 32'h11112222}));
      mif.mem_rsp_valid = 1'b0;
      core_req = '0;
      tick();
      chk("done0", 64'({core_ack, core_grant}), 64'h0);

      // Single read by core 2; calibration dropping is ignored now
      mif.mem_calib_done = 1'b0;
      core_req = 4'b0100;
      core_addr[2*AW +: AW] = 28'h0000100;
      mif.mem_cmd_ready = 1'b1;
      tick();
      chk("rd_cmd", 64'({core_grant, mif.mem_cmd_valid, mif.mem_cmd_wr,
                         mif.mem_cmd_addr}),
          64'({4'b0100, 1'b1, 1'b0, 28'h0000100}));
      tick();
      chk("rd_hs", 64'(mif.mem_cmd_valid), 64'h0);
      mif.mem_rsp_valid = 1'b1;
      mif.mem_rsp_rdata = 32'hCAFECAFE;
      tick();
      chk("rd_ack", 64'({core_ack, core_err, core_rdata}),
          64'({4'b0100, 1'b0, 32'hCAFECAFE}));
      mif.mem_rsp_valid = 1'b0;
      core_req = '0;
      tick();
      chk("rd_done", 64'({core_ack, core_err, core_grant}), 64'h0);

      // Round robin: pointer sits at core 2, so order is 3,0,1,2,3
      for (int i = 0; i < NC; i++) core_addr[i*AW +: AW] = 28'(32'h1000 + i);
      core_req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("rr_grant", 64'(core_grant), 64'(4'b0001 << order[n]));
         chk("rr_addr", 64'(mif.mem_cmd_addr), 64'(32'h1000 + order[n]));
         tick();
         mif.mem_rsp_valid = 1'b1;
         mif.mem_rsp_rdata = 32'hA0000000 + 32'(n);
         tick();
         chk("rr_ack", 64'({core_ack, core_err, core_rdata}),
             64'({4'(4'b0001 << order[n]), 1'b0, 32'hA0000000 + 32'(n)}));
         mif.mem_rsp_valid = 1'b0;
         tick();
         chk("rr_done", 64'(core_ack), 64'h0);
      end

      // Backpressure on a write from core 1; inputs change after grant
      core_req = 4'b0010;
      core_wren = 4'b0010;
      core_addr[1*AW +: AW] = 28'h0000040;
      core_wdata[1*DW +: DW] = 32'hBEADBEAD;
      mif.mem_cmd_ready = 1'b0;
      tick();
      chk("bp_grant", 64'(core_grant), 64'h2);
      core_addr[1*AW +: AW] = 28'hFFFFFFF;
      core_wdata[1*DW +: DW] = 32'h0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold", 64'({mif.mem_cmd_valid, mif.mem_cmd_wr,
                             mif.mem_cmd_addr, mif.mem_cmd_wdata}),
             64'({1'b1, 1'b1, 28'h0000040, 32'hBEADBEAD}));
      end
      mif.mem_cmd_ready = 1'b1;
      tick();
      chk("bp_hs", 64'(mif.mem_cmd_valid), 64'h0);
      mif.mem_cmd_ready = 1'b0;
      core_req = '0;
      tick();
      chk("bp_single_hs", 64'({mif.mem_cmd_valid, core_ack}), 64'h0);
      mif.mem_rsp_valid = 1'b1;
      mif.mem_rsp_rdata = 32'h0BAD0BAD;
      tick();
      chk("bp_ack", 64'({core_ack, core_err, core_rdata}),
          64'({4'b0010, 1'b0, 32'hA0000004}));
      mif.mem_rsp_valid = 1'b0;
      core_wren = '0;
      tick();
      chk("bp_done", 64'({core_ack, core_grant}), 64'h0);

      // Timeout on a read from core 3
      core_req = 4'b1000;
      core_addr[3*AW +: AW] = 28'h0000300;
      mif.mem_cmd_ready = 1'b1;
      tick();
      chk("to_grant", 64'(core_grant), 64'h8);
      tick();
      chk("to_hs", 64'(mif.mem_cmd_valid), 64'h0);
      mif.mem_cmd_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("to_wait", 64'({core_ack, core_err}), 64'h0);
      end
      tick();
      chk("to_fire", 64'({core_ack, core_err, core_rdata}),
          64'({4'b1000, 1'b1, 32'h0}));
      core_req = '0;
      mif.mem_rsp_valid = 1'b1;
      mif.mem_rsp_rdata = 32'hDEADDEAD;
      tick();
      chk("to_stray1", 64'({core_ack, core_err, core_grant, core_rdata}),
          64'h0);
      tick();
      chk("to_stray2", 64'({core_ack, core_err, core_rdata}), 64'h0);
      mif.mem_rsp_valid = 1'b0;

      // Reset while waiting for a response
      mif.mem_calib_done = 1'b1;
      core_req = 4'b0001;
      core_addr[0*AW +: AW] = 28'h0000AA0;
      mif.mem_cmd_ready = 1'b1;
      tick();
      chk("mr_grant", 64'(core_grant), 64'h1);
      tick();
      reset = 1'b0;
      mif.mem_rsp_valid = 1'b1;
      mif.mem_rsp_rdata = 32'h12345678;
      tick();
      chk("mr_out", 64'({core_grant, core_ack, core_err, core_rdata}), 64'h0);
      chk("mr_cmd", 64'({mif.mem_cmd_valid, mif.mem_cmd_wr,
                         mif.mem_cmd_addr, mif.mem_cmd_wdata}), 64'h0);
      reset = 1'b1;
      mif.mem_rsp_valid = 1'b0;
      tick();
      chk("mr_init", 64'({core_ack, core_grant, mif.mem_cmd_valid}), 64'h0);
      tick();
      chk("mr_rr_restart", 64'(core_grant), 64'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
